// File: rtl/prog_instr_mem.sv
// prog_instr_mem
//   Run-time loadable instruction memory for the lab CPU.
//   After reset the whole array is filled with DEFAULT_WORD, one word per cycle.
//   The CPU then fetches through a 1-cycle registered read port. A loader can
//   download a new program through a valid/ready write port whose pointer
//   auto-increments from a chosen base address.
//
// Ports
//   Clock, Reset   : rising-edge clock, synchronous active-high reset
//   iAddress       : CPU fetch address (16 bit)
//   oInstruction   : registered fetched word (DEFAULT_WORD outside RUN / out of range)
//   oReady         : high in RUN (memory contents valid, a load may start)
//   iLoadStart     : pulse, starts a load session at iLoadBase (RUN only)
//   iLoadBase      : first write address of the session
//   iWrValid/iWrData/oWrReady : loader word handshake (ready only in LOAD)
//   iLoadEnd       : pulse, ends the load session
//   oLoadDone      : one-cycle pulse on every LOAD->RUN transition
//   oWordCount     : words accepted in the current/last load session
module prog_instr_mem #(
  parameter int unsigned          DATA_W       = 28,
  parameter int unsigned          ADDR_W       = 8,
  parameter logic [DATA_W-1:0]    DEFAULT_WORD = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       iAddress,
  output logic [DATA_W-1:0] oInstruction,
  output logic              oReady,
  input  logic              iLoadStart,
  input  logic [ADDR_W-1:0] iLoadBase,
  input  logic              iWrValid,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrReady,
  input  logic              iLoadEnd,
  output logic              oLoadDone,
  output logic [ADDR_W:0]   oWordCount
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                we;
  logic [DATA_W-1:0]   wdata;
  logic                fetch_in_range;

  // Upper address bits beyond the array must read as DEFAULT_WORD, not alias.
  assign fetch_in_range = (32'(iAddress) < DEPTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    instr_d = DEFAULT_WORD;
    done_d  = 1'b0;
    we      = 1'b0;
    wdata   = DEFAULT_WORD;

    unique case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (fetch_in_range) begin
          instr_d = mem_q[iAddress[ADDR_W-1:0]];
        end
        if (iLoadStart) begin
          state_d = S_LOAD;
          ptr_d   = iLoadBase;
          count_d = '0;
        end
      end

      S_LOAD: begin
        if (iWrValid) begin
          we      = 1'b1;
          wdata   = iWrData;
          ptr_d   = ptr_q + 1'b1;
          count_d = count_q + 1'b1;
        end
        // Writing the last location ends the session instead of wrapping.
        if (iLoadEnd || (iWrValid && (ptr_q == PTR_LAST))) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      count_q <= '0;
      instr_q <= DEFAULT_WORD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      instr_q <= instr_d;
      done_q  <= done_d;
    end
  end

  // Storage has no reset; the CLEAR sweep initialises it.
  always_ff @(posedge Clock) begin
    if (we && !Reset) begin
      mem_q[ptr_q] <= wdata;
    end
  end

  assign oInstruction = instr_q;
  assign oReady       = (state_q == S_RUN);
  assign oWrReady     = (state_q == S_LOAD);
  assign oLoadDone    = done_q;
  assign oWordCount   = count_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// tb_prog_instr_mem
//   Directed test of prog_instr_mem with ADDR_W=4, DATA_W=28: clear sweep,
//   load sessions (normal, end-of-memory, gapped handshake), out-of-range
//   fetch and reset during a load.
module tb_prog_instr_mem;

  localparam int unsigned DATA_W = 28;
  localparam int unsigned ADDR_W = 4;

  logic              Clock;
  logic              Reset;
  logic [15:0]       iAddress;
  logic [DATA_W-1:0] oInstruction;
  logic              oReady;
  logic              iLoadStart;
  logic [ADDR_W-1:0] iLoadBase;
  logic              iWrValid;
  logic [DATA_W-1:0] iWrData;
  logic              oWrReady;
  logic              iLoadEnd;
  logic              oLoadDone;
  logic [ADDR_W:0]   oWordCount;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  prog_instr_mem #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEFAULT_WORD(28'h0)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iAddress    (iAddress),
    .oInstruction(oInstruction),
    .oReady      (oReady),
    .iLoadStart  (iLoadStart),
    .iLoadBase   (iLoadBase),
    .iWrValid    (iWrValid),
    .iWrData     (iWrData),
    .oWrReady    (oWrReady),
    .iLoadEnd    (iLoadEnd),
    .oLoadDone   (oLoadDone),
    .oWordCount  (oWordCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Present address, one edge later the registered word is visible.
  task automatic fetch_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    iAddress = addr;
    tick();
    chk(tag, 32'(oInstruction), exp);
  endtask

  task automatic wait_clear(input string tag);
    int unsigned n;
    n = 0;
    while (!oReady && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, 32'd16);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base);
    iLoadStart = 1'b1;
    iLoadBase  = base;
    tick();
    iLoadStart = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    iAddress   = '0;
    iLoadStart = 1'b0;
    iLoadBase  = '0;
    iWrValid   = 1'b0;
    iWrData    = '0;
    iLoadEnd   = 1'b0;

    // 1. reset state and clear sweep
    tick();
    chk("rst_instr", 32'(oInstruction), 32'h0);
    chk("rst_ready", 32'(oReady), 32'd0);
    chk("rst_wrready", 32'(oWrReady), 32'd0);
    chk("rst_done", 32'(oLoadDone), 32'd0);
    chk("rst_count", 32'(oWordCount), 32'd0);
    Reset = 1'b0;
    // load requests during CLEAR must be ignored
    iLoadStart = 1'b1;
    iWrValid   = 1'b1;
    iWrData    = 28'h0ABCDEF;
    wait_clear("clear_len");
    iLoadStart = 1'b0;
    iWrValid   = 1'b0;
    chk("clear_wrready", 32'(oWrReady), 32'd0);
    for (int i = 0; i < 16; i++) fetch_chk("clear_fetch", 16'(i), 32'h0);

    // 2. load three words from base 0
    iAddress = 16'd2;
    start_load(4'd0);
    chk("ld_wrready", 32'(oWrReady), 32'd1);
    chk("ld_ready", 32'(oReady), 32'd0);
    iWrValid = 1'b1;
    iWrData = 28'h0400FA0; tick();
    iWrData = 28'h0500001; tick();
    iWrData = 28'h0600048; tick();
    chk("ld_nop", 32'(oInstruction), 32'h0);
    iWrValid = 1'b0;
    iLoadEnd = 1'b1;
    tick();
    iLoadEnd = 1'b0;
    chk("ld_done", 32'(oLoadDone), 32'd1);
    chk("ld_count", 32'(oWordCount), 32'd3);
    chk("ld_ready_back", 32'(oReady), 32'd1);
    fetch_chk("ld_fetch2", 16'd2, 32'h0600048);
    chk("ld_done_pulse", 32'(oLoadDone), 32'd0);
    chk("ld_count_hold", 32'(oWordCount), 32'd3);
    fetch_chk("ld_fetch0", 16'd0, 32'h0400FA0);
    fetch_chk("ld_fetch1", 16'd1, 32'h0500001);
    fetch_chk("ld_fetch3", 16'd3, 32'h0);

    // 3. out-of-range fetch (0x0010 would alias to address 0)
    fetch_chk("oor_10", 16'h0010, 32'h0);
    fetch_chk("oor_ffff", 16'hFFFF, 32'h0);

    // 4. base 14, three words offered: auto-end after address 15
    start_load(4'd14);
    iWrValid = 1'b1;
    iWrData = 28'h0ABCDE1; tick();
    chk("top_wrready", 32'(oWrReady), 32'd1);
    iWrData = 28'h0ABCDE2; tick();
    chk("top_autoend_wrready", 32'(oWrReady), 32'd0);
    chk("top_done", 32'(oLoadDone), 32'd1);
    chk("top_count", 32'(oWordCount), 32'd2);
    iWrData = 28'h0ABCDE3; tick();
    iWrValid = 1'b0;
    chk("top_done_pulse", 32'(oLoadDone), 32'd0);
    chk("top_count_hold", 32'(oWordCount), 32'd2);
    fetch_chk("top_fetch14", 16'd14, 32'h0ABCDE1);
    fetch_chk("top_fetch15", 16'd15, 32'h0ABCDE2);
    fetch_chk("top_fetch0", 16'd0, 32'h0400FA0);
    fetch_chk("top_oor_ffff", 16'hFFFF, 32'h0);

    // 5. gapped handshake, iLoadEnd coincident with second accepted word
    iAddress = 16'd2;
    start_load(4'd4);
    iWrValid = 1'b1; iWrData = 28'h0111111; tick();
    chk("gap_nop1", 32'(oInstruction), 32'h0);
    iWrValid = 1'b0; iWrData = 28'h0FFFFFF; tick();
    chk("gap_nop2", 32'(oInstruction), 32'h0);
    chk("gap_wrready", 32'(oWrReady), 32'd1);
    chk("gap_count1", 32'(oWordCount), 32'd1);
    iWrValid = 1'b1; iWrData = 28'h0222222; iLoadEnd = 1'b1; tick();
    iWrValid = 1'b0; iLoadEnd = 1'b0;
    chk("gap_done", 32'(oLoadDone), 32'd1);
    chk("gap_count", 32'(oWordCount), 32'd2);
    fetch_chk("gap_fetch4", 16'd4, 32'h0111111);
    fetch_chk("gap_fetch5", 16'd5, 32'h0222222);
    fetch_chk("gap_fetch6", 16'd6, 32'h0);

    // 6. reset in the middle of a load
    start_load(4'd8);
    iWrValid = 1'b1; iWrData = 28'h0333333; tick();
    Reset = 1'b1; tick();
    Reset = 1'b0; iWrValid = 1'b0;
    chk("mid_rst_ready", 32'(oReady), 32'd0);
    chk("mid_rst_wrready", 32'(oWrReady), 32'd0);
    chk("mid_rst_count", 32'(oWordCount), 32'd0);
    wait_clear("mid_clear_len");
    chk("mid_count_after", 32'(oWordCount), 32'd0);
    for (int i = 0; i < 16; i++) fetch_chk("mid_fetch", 16'(i), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
